// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA raster timing generator and scan-out stage.
// A pixel-rate tick from an HCLK divider advances the horizontal/vertical
// counters. The counters drive the frame-buffer read address directly. The
// returned pixel is turned into registered RGB444, and hsync/vsync are
// registered on the same tick so that all three stay aligned.
module vga_scan_out #(
  parameter int          CLK_DIV   = 2,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [11:0] FG_COLOUR = 12'hFFF,
  parameter logic [11:0] BG_COLOUR = 12'h000
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       pixel,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  logic tick;
  logic frame_wrap;
  logic visible;

  // Pixel-rate strobe, visible-area decode and the read address.
  always_comb begin
    tick       = (div_q == DIV_LAST);
    frame_wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);
    visible    = (h_q < H_VIS) && (v_q < V_VIS);
    pixel_x    = visible ? h_q : '0;
    pixel_y    = visible ? v_q[8:0] : '0;
  end

  // Divider and raster counters; vertical advances on the last pixel of a line.
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Output stage loads on the tick from pre-advance counters; pixel data
  // arrived one cycle earlier for the same address, so everything lines up.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick) begin
      rgb_d   = visible ? (pixel ? FG_COLOUR : BG_COLOUR) : 12'h000;
      hsync_d = !((h_q >= HS_START) && (h_q <= HS_END));
      vsync_d = !((v_q >= VS_START) && (v_q <= VS_END));
    end
    frame_start_d = frame_wrap;
  end

  // State registers with synchronous active-low reset; a mid-frame reset
  // simply restarts the raster.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Registered outputs.
  always_comb begin
    {red, green, blue} = rgb_q;
    hsync              = hsync_q;
    vsync              = vsync_q;
    frame_start        = frame_start_q;
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: one instance at default 640x480 timing and one
// shrunken-raster instance (divide-by-3, red foreground, non-zero
// background) for whole-frame behaviour.
module tb_vga_scan_out;

  localparam int S_DIV = 3;
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME_CYC = S_HT * S_VT * S_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst_a;
  logic       pix_a;
  logic [9:0] px_a;
  logic [8:0] py_a;
  logic       hs_a, vs_a, fs_a;
  logic [3:0] r_a, g_a, b_a;

  // small instance
  logic       rst_s;
  logic       pix_s;
  logic [9:0] px_s;
  logic [8:0] py_s;
  logic       hs_s, vs_s, fs_s;
  logic [3:0] r_s, g_s, b_s;

  vga_scan_out dut (
    .HCLK(clk), .HRESETn(rst_a), .pixel(pix_a),
    .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a)
  );

  vga_scan_out #(
    .CLK_DIV(S_DIV),
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FG_COLOUR(12'hF00), .BG_COLOUR(12'h00A)
  ) dut_s (
    .HCLK(clk), .HRESETn(rst_s), .pixel(pix_s),
    .pixel_x(px_s), .pixel_y(py_s), .hsync(hs_s), .vsync(vs_s),
    .red(r_s), .green(g_s), .blue(b_s), .frame_start(fs_s)
  );

  // 1-cycle-latency frame buffers with only pixel (5,3) lit
  always @(posedge clk) begin
    pix_a <= (px_a == 10'd5) && (py_a == 9'd3);
    pix_s <= (px_s == 10'd5) && (py_s == 9'd3);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs_a();
    return {30'b0, px_a, py_a, hs_a, vs_a, r_a, g_a, b_a, fs_a};
  endfunction

  function automatic logic [63:0] obs_s();
    return {30'b0, px_s, py_s, hs_s, vs_s, r_s, g_s, b_s, fs_s};
  endfunction

  localparam logic [63:0] RESET_VEC = {30'b0, 10'd0, 9'd0, 1'b1, 1'b1, 12'h000, 1'b0};

  // expected small-instance outputs n edges after reset release
  function automatic logic [63:0] model_s(input int n);
    int tk, h, v, t, ht, vt;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        hs, vs, fs;
    logic [11:0] rgb;
    tk = n / S_DIV;
    h  = tk % S_HT;
    v  = (tk / S_HT) % S_VT;
    px = '0;
    py = '0;
    if (h < S_HV && v < S_VV) begin
      px = 10'(h);
      py = 9'(v);
    end
    hs  = 1'b1;
    vs  = 1'b1;
    rgb = '0;
    if (tk > 0) begin
      t  = tk - 1;
      ht = t % S_HT;
      vt = (t / S_HT) % S_VT;
      hs = !(ht >= S_HV + S_HF && ht <= S_HV + S_HF + S_HS - 1);
      vs = !(vt >= S_VV + S_VF && vt <= S_VV + S_VF + S_VS - 1);
      if (ht < S_HV && vt < S_VV) rgb = (ht == 5 && vt == 3) ? 12'hF00 : 12'h00A;
    end
    fs = (n > 0) && (n % S_FRAME_CYC == 0);
    return {30'b0, px, py, hs, vs, rgb, fs};
  endfunction

  typedef struct {
    int          cyc;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int idx;
    int fall1, fall2, rise1;
    int fs_pulses, max_px, max_py;
    logic prev_hs;
    logic [63:0] exp_v;

    // {cycle after release, pixel_x, pixel_y, hsync, vsync, rgb, frame_start}
    tbl[0]  = '{0,    10'd0,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[1]  = '{1,    10'd0,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[2]  = '{2,    10'd1,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[3]  = '{3,    10'd1,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[4]  = '{4,    10'd2,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[5]  = '{1279, 10'd639, 9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[6]  = '{1280, 10'd0,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[7]  = '{1313, 10'd0,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[8]  = '{1314, 10'd0,   9'd0, 1'b0, 1'b1, 12'h000, 1'b0};
    tbl[9]  = '{1504, 10'd0,   9'd0, 1'b0, 1'b1, 12'h000, 1'b0};
    tbl[10] = '{1506, 10'd0,   9'd0, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[11] = '{1600, 10'd0,   9'd1, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[12] = '{1602, 10'd1,   9'd1, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[13] = '{3212, 10'd6,   9'd2, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[14] = '{4810, 10'd5,   9'd3, 1'b1, 1'b1, 12'h000, 1'b0};
    tbl[15] = '{4812, 10'd6,   9'd3, 1'b1, 1'b1, 12'hFFF, 1'b0};
    tbl[16] = '{4813, 10'd6,   9'd3, 1'b1, 1'b1, 12'hFFF, 1'b0};
    tbl[17] = '{4814, 10'd7,   9'd3, 1'b1, 1'b1, 12'h000, 1'b0};

    rst_a = 1'b0;
    rst_s = 1'b0;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold_a", obs_a(), RESET_VEC);
    end
    rst_a = 1'b1;

    // default-timing vectors, with hsync edge timing recorded on the way
    idx = 0;
    fall1 = -1; fall2 = -1; rise1 = -1;
    prev_hs = hs_a;
    for (int n = 0; n <= 4814; n++) begin
      if (n > 0) step();
      if (prev_hs && !hs_a) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      if (!prev_hs && hs_a && rise1 < 0 && fall1 >= 0) rise1 = n;
      prev_hs = hs_a;
      if (idx < 18 && tbl[idx].cyc == n) begin
        exp_v = {30'b0, tbl[idx].px, tbl[idx].py, tbl[idx].hs, tbl[idx].vs, tbl[idx].rgb, tbl[idx].fs};
        chk($sformatf("vec_cyc%0d", n), obs_a(), exp_v);
        idx++;
      end
    end
    chk("hsync_first_fall", 64'(fall1), 64'd1314);
    chk("hsync_period", 64'(fall2 - fall1), 64'd1600);
    chk("hsync_low_width", 64'(rise1 - fall1), 64'd192);
    chk("reset_hold_small", obs_s(), RESET_VEC);

    // small raster: two frames plus part of a third against the model
    rst_s = 1'b1;
    fs_pulses = 0; max_px = 0; max_py = 0;
    for (int n = 0; n <= 1330; n++) begin
      if (n > 0) step();
      chk($sformatf("small_cyc%0d", n), obs_s(), model_s(n));
      if (fs_s) fs_pulses++;
      if (int'(px_s) > max_px) max_px = int'(px_s);
      if (int'(py_s) > max_py) max_py = int'(py_s);
      if (n == 162) begin
        chk("fg_red", 64'(r_s), 64'hF);
        chk("fg_green", 64'(g_s), 64'h0);
        chk("fg_blue", 64'(b_s), 64'h0);
      end
    end
    chk("frame_start_count", 64'(fs_pulses), 64'd2);
    chk("max_pixel_x", 64'(max_px), 64'(S_HV - 1));
    chk("max_pixel_y", 64'(max_py), 64'(S_VV - 1));

    // one-cycle reset in the middle of the vsync/hsync window
    chk("pre_reset_syncs", {62'b0, hs_s, vs_s}, 64'd0);
    rst_s = 1'b0;
    step();
    chk("midframe_reset", obs_s(), RESET_VEC);
    rst_s = 1'b1;
    for (int n = 0; n <= 600; n++) begin
      if (n > 0) step();
      chk($sformatf("restart_cyc%0d", n), obs_s(), model_s(n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
